// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, ALU ops,
// FSM states and the small select/cause codes driven to the datapath.
package cpu_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // funct7 values that the base integer ISA allows
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_DECODE = 3'd2;
  localparam state_t ST_EXEC   = 3'd3;
  localparam state_t ST_MEM    = 3'd4;
  localparam state_t ST_WB     = 3'd5;
  localparam state_t ST_TRAP   = 3'd6;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  // Common funct3 -> ALU op mapping for R-type and I-type ALU instructions;
  // alt selects SUB/SRA (funct7 bit 5)
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational instruction classifier: picks the ALU operation and operand-B
// source for an IR, and flags encodings outside the supported RV32I subset.
module alu_op_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       alu_src_b,
  output logic       illegal
);

  // Decode opcode/funct fields into ALU control and the illegal flag
  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_R: begin
        alu_op  = alu_from_funct3(funct3, funct7 == F7_ALT);
        illegal = !((funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
      end
      OP_IMM: begin
        alu_src_b = 1'b1;
        alu_op    = alu_from_funct3(funct3, (funct3 == 3'd5) && (funct7 == F7_ALT));
        if (funct3 == 3'd1)
          illegal = (funct7 != F7_BASE);
        else if (funct3 == 3'd5)
          illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end
      OP_LOAD: begin
        alu_src_b = 1'b1;
        illegal   = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OP_STORE: begin
        alu_src_b = 1'b1;
        illegal   = (funct3 > 3'd2);
      end
      OP_BRANCH: begin
        case (funct3)
          3'd0, 3'd1: alu_op = ALU_SUB;
          3'd4, 3'd5: alu_op = ALU_SLT;
          3'd6, 3'd7: alu_op = ALU_SLTU;
          default:    illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        alu_op = ALU_ADD;
      end
      OP_LUI: begin
        alu_src_b = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a
// shared memory port, with a memory watchdog, trap state and retire counter.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int RET_CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 alu_zero,
  input  logic                 alu_lt,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 trap_clear,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 dmem_req,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 alu_src_b,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [RET_CNT_W-1:0] retired
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t               state_q, state_d;
  logic [7:0]           wait_q, wait_d;
  logic [1:0]           cause_q, cause_d;
  logic [RET_CNT_W-1:0] retired_q, retired_d;
  logic                 retire;

  logic [3:0] dec_alu_op;
  logic       dec_src_b;
  logic       dec_illegal;

  logic is_load, is_store, is_branch, is_jal, is_lui, br_taken;

  alu_op_decoder u_dec (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .alu_op    (dec_alu_op),
    .alu_src_b (dec_src_b),
    .illegal   (dec_illegal)
  );

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_lui    = (opcode == OP_LUI);
  // funct3[2] picks lt vs zero, funct3[0] inverts (bne/bge/bgeu)
  assign br_taken  = (funct3[2] ? alu_lt : alu_zero) ^ funct3[0];

  // Next-state, watchdog and Moore-plus-decode control outputs
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    cause_d   = cause_q;
    retire    = 1'b0;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    dmem_req  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_op    = '0;
    alu_src_b = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    trap      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        wait_d  = '0;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (wait_q == TIMEOUT) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IMEM;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op    = ALU_OP_W'(dec_alu_op);
        alu_src_b = dec_src_b;
        if (is_load || is_store) begin
          state_d = ST_MEM;
          wait_d  = '0;
        end else if (is_branch) begin
          pc_write = 1'b1;
          pc_src   = br_taken ? PC_BRANCH : PC_PLUS4;
          retire   = 1'b1;
          state_d  = ST_FETCH;
          wait_d   = '0;
        end else if (is_jal) begin
          pc_write  = 1'b1;
          pc_src    = PC_JAL;
          reg_write = 1'b1;
          wb_sel    = WB_PC4;
          retire    = 1'b1;
          state_d   = ST_FETCH;
          wait_d    = '0;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req  = 1'b1;
        mem_read  = is_load;
        mem_write = is_store;
        if (dmem_ready) begin
          if (is_load) begin
            state_d = ST_WB;
          end else begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = ST_FETCH;
            wait_d   = '0;
          end
        end else if (wait_q == TIMEOUT) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_load ? WB_MEM : (is_lui ? WB_IMM : WB_ALU);
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
        wait_d    = '0;
      end
      ST_TRAP: begin
        trap = 1'b1;
        if (trap_clear) begin
          state_d = ST_FETCH;
          cause_d = CAUSE_NONE;
          wait_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    retired_d = retired_q + RET_CNT_W'(retire);
  end

  // State, wait counter, trap cause and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected control traces
// built from the instruction-level rules, table-driven plus randomized runs.
module tb_multicycle_control_unit;

  localparam int TO = 15;

  localparam int K_ALU   = 0;
  localparam int K_LUI   = 1;
  localparam int K_LOAD  = 2;
  localparam int K_STORE = 3;
  localparam int K_BR    = 4;
  localparam int K_JAL   = 5;
  localparam int K_ILL   = 6;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       dmem_req;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] alu_op;
    logic       alu_src_b;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       trap;
    logic [1:0] trap_cause;
  } ctrl_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] aluOp;
    logic       srcB;
    int         kind;
  } vec_t;

  typedef struct {
    ctrl_t exp;
    logic  iRdy;
    logic  dRdy;
    logic  clr;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        alu_zero, alu_lt, imem_ready, dmem_ready, trap_clear;
  logic        imem_req, ir_write, pc_write, dmem_req, mem_read, mem_write;
  logic [1:0]  pc_src, wb_sel, trap_cause;
  logic [3:0]  alu_op;
  logic        alu_src_b, reg_write, trap;
  logic [31:0] retired;
  ctrl_t       got;

  int nCompared    = 0;
  int nMismatched  = 0;
  int modelRetired = 0;
  vec_t vecs[$];
  cyc_t trace[$];

  always #5 clk = ~clk;

  assign got = {imem_req, ir_write, pc_write, pc_src, dmem_req, mem_read, mem_write,
                alu_op, alu_src_b, reg_write, wb_sel, trap, trap_cause};

  multicycle_control_unit #(.ALU_OP_W(4), .MEM_TIMEOUT(TO), .RET_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .trap_clear(trap_clear), .imem_req(imem_req),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .dmem_req(dmem_req),
    .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause),
    .retired(retired)
  );

  function automatic void addVec(input string name, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [3:0] aluOp,
                                 input logic srcB, input int kind);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.f7 = f7;
    v.aluOp = aluOp; v.srcB = srcB; v.kind = kind;
    vecs.push_back(v);
  endfunction

  function automatic int findVec(input string name);
    foreach (vecs[i]) if (vecs[i].name == name) return i;
    return 0;
  endfunction

  function automatic logic branchTaken(input logic [2:0] f3, input logic z, input logic lt);
    case (f3)
      3'd0:       return z;
      3'd1:       return !z;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic void pushCycle(input ctrl_t e, input logic i, input logic d, input logic c);
    cyc_t cy;
    cy.exp = e; cy.iRdy = i; cy.dRdy = d; cy.clr = c;
    trace.push_back(cy);
  endfunction

  // A trap lasts two observed cycles; trap_clear is pulsed in the second
  function automatic void pushTrap(input logic [1:0] cause);
    ctrl_t e;
    e = '0; e.trap = 1'b1; e.trap_cause = cause;
    pushCycle(e, 1'b0, 1'b0, 1'b0);
    pushCycle(e, 1'b0, 1'b0, 1'b1);
  endfunction

  // Reference model: expected per-cycle controls for one instruction with
  // iw fetch wait cycles and dw data wait cycles; returns 1 if it retires
  function automatic bit buildTrace(input vec_t v, input int iw, input int dw,
                                    input logic z, input logic lt);
    ctrl_t e;
    int n;
    trace.delete();
    n = (iw > TO) ? TO + 1 : iw + 1;
    for (int k = 0; k < n; k++) begin
      e = '0; e.imem_req = 1'b1; e.ir_write = (k == iw);
      pushCycle(e, k == iw, 1'b0, 1'b0);
    end
    if (iw > TO) begin pushTrap(2'd2); return 1'b0; end
    pushCycle('0, 1'b0, 1'b0, 1'b0);
    if (v.kind == K_ILL) begin pushTrap(2'd1); return 1'b0; end
    e = '0; e.alu_op = v.aluOp; e.alu_src_b = v.srcB;
    if (v.kind == K_BR) begin
      e.pc_write = 1'b1;
      e.pc_src   = branchTaken(v.f3, z, lt) ? 2'd1 : 2'd0;
      pushCycle(e, 1'b0, 1'b0, 1'b0);
      return 1'b1;
    end
    if (v.kind == K_JAL) begin
      e.pc_write = 1'b1; e.pc_src = 2'd2; e.reg_write = 1'b1; e.wb_sel = 2'd2;
      pushCycle(e, 1'b0, 1'b0, 1'b0);
      return 1'b1;
    end
    pushCycle(e, 1'b0, 1'b0, 1'b0);
    if (v.kind == K_LOAD || v.kind == K_STORE) begin
      n = (dw > TO) ? TO + 1 : dw + 1;
      for (int k = 0; k < n; k++) begin
        e = '0; e.dmem_req = 1'b1;
        e.mem_read  = (v.kind == K_LOAD);
        e.mem_write = (v.kind == K_STORE);
        e.pc_write  = (k == dw) && (v.kind == K_STORE);
        pushCycle(e, 1'b0, k == dw, 1'b0);
      end
      if (dw > TO) begin pushTrap(2'd3); return 1'b0; end
      if (v.kind == K_STORE) return 1'b1;
    end
    e = '0; e.reg_write = 1'b1; e.pc_write = 1'b1;
    e.wb_sel = (v.kind == K_LOAD) ? 2'd1 : ((v.kind == K_LUI) ? 2'd3 : 2'd0);
    pushCycle(e, 1'b0, 1'b0, 1'b0);
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Plays the current trace one cycle per negedge, then steps past the last edge
  task automatic applyStimulus(input string tag);
    for (int k = 0; k < trace.size(); k++) begin
      @(negedge clk);
      imem_ready = trace[k].iRdy;
      dmem_ready = trace[k].dRdy;
      trap_clear = trace[k].clr;
      #1;
      checkOutput($sformatf("%s.c%0d", tag, k), {13'b0, got}, {13'b0, trace[k].exp});
    end
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    trap_clear = 1'b0;
  endtask

  task automatic runInstr(input string tag, input vec_t v, input int iw, input int dw,
                          input logic z, input logic lt);
    bit retires;
    opcode = v.op; funct3 = v.f3; funct7 = v.f7; alu_zero = z; alu_lt = lt;
    retires = buildTrace(v, iw, dw, z, lt);
    applyStimulus(tag);
    if (retires) modelRetired++;
    checkOutput({tag, ".retired"}, retired, 32'(modelRetired));
  endtask

  // Releases rst_n at a negedge; one IDLE cycle, then FETCH
  task automatic releaseReset(input string tag);
    ctrl_t e;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput({tag, ".idle"}, {13'b0, got}, 32'd0);
    @(posedge clk);
    #1;
    e = '0; e.imem_req = 1'b1;
    checkOutput({tag, ".fetch"}, {13'b0, got}, {13'b0, e});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    vec_t  v;
    ctrl_t e;
    int    iw, dw, r;

    addVec("add",   7'h33, 3'd0, 7'h00, 4'd0, 1'b0, K_ALU);
    addVec("sub",   7'h33, 3'd0, 7'h20, 4'd1, 1'b0, K_ALU);
    addVec("sll",   7'h33, 3'd1, 7'h00, 4'd6, 1'b0, K_ALU);
    addVec("slt",   7'h33, 3'd2, 7'h00, 4'd3, 1'b0, K_ALU);
    addVec("sltu",  7'h33, 3'd3, 7'h00, 4'd9, 1'b0, K_ALU);
    addVec("xor",   7'h33, 3'd4, 7'h00, 4'd5, 1'b0, K_ALU);
    addVec("srl",   7'h33, 3'd5, 7'h00, 4'd7, 1'b0, K_ALU);
    addVec("sra",   7'h33, 3'd5, 7'h20, 4'd8, 1'b0, K_ALU);
    addVec("or",    7'h33, 3'd6, 7'h00, 4'd2, 1'b0, K_ALU);
    addVec("and",   7'h33, 3'd7, 7'h00, 4'd4, 1'b0, K_ALU);
    addVec("r_f7",  7'h33, 3'd1, 7'h20, 4'd0, 1'b0, K_ILL);
    addVec("r_mul", 7'h33, 3'd0, 7'h01, 4'd0, 1'b0, K_ILL);
    addVec("addi",  7'h13, 3'd0, 7'h55, 4'd0, 1'b1, K_ALU);
    addVec("slti",  7'h13, 3'd2, 7'h00, 4'd3, 1'b1, K_ALU);
    addVec("sltiu", 7'h13, 3'd3, 7'h7f, 4'd9, 1'b1, K_ALU);
    addVec("xori",  7'h13, 3'd4, 7'h00, 4'd5, 1'b1, K_ALU);
    addVec("ori",   7'h13, 3'd6, 7'h12, 4'd2, 1'b1, K_ALU);
    addVec("andi",  7'h13, 3'd7, 7'h00, 4'd4, 1'b1, K_ALU);
    addVec("slli",  7'h13, 3'd1, 7'h00, 4'd6, 1'b1, K_ALU);
    addVec("srli",  7'h13, 3'd5, 7'h00, 4'd7, 1'b1, K_ALU);
    addVec("srai",  7'h13, 3'd5, 7'h20, 4'd8, 1'b1, K_ALU);
    addVec("slli_bad", 7'h13, 3'd1, 7'h20, 4'd0, 1'b0, K_ILL);
    addVec("srli_bad", 7'h13, 3'd5, 7'h01, 4'd0, 1'b0, K_ILL);
    addVec("lw",    7'h03, 3'd2, 7'h00, 4'd0, 1'b1, K_LOAD);
    addVec("lbu",   7'h03, 3'd4, 7'h3f, 4'd0, 1'b1, K_LOAD);
    addVec("ld",    7'h03, 3'd3, 7'h00, 4'd0, 1'b0, K_ILL);
    addVec("lwu",   7'h03, 3'd6, 7'h00, 4'd0, 1'b0, K_ILL);
    addVec("sw",    7'h23, 3'd2, 7'h00, 4'd0, 1'b1, K_STORE);
    addVec("sb",    7'h23, 3'd0, 7'h11, 4'd0, 1'b1, K_STORE);
    addVec("sd",    7'h23, 3'd3, 7'h00, 4'd0, 1'b0, K_ILL);
    addVec("beq",   7'h63, 3'd0, 7'h00, 4'd1, 1'b0, K_BR);
    addVec("bne",   7'h63, 3'd1, 7'h00, 4'd1, 1'b0, K_BR);
    addVec("blt",   7'h63, 3'd4, 7'h00, 4'd3, 1'b0, K_BR);
    addVec("bge",   7'h63, 3'd5, 7'h00, 4'd3, 1'b0, K_BR);
    addVec("bltu",  7'h63, 3'd6, 7'h00, 4'd9, 1'b0, K_BR);
    addVec("bgeu",  7'h63, 3'd7, 7'h00, 4'd9, 1'b0, K_BR);
    addVec("br_bad", 7'h63, 3'd2, 7'h00, 4'd0, 1'b0, K_ILL);
    addVec("jal",   7'h6f, 3'd5, 7'h7f, 4'd0, 1'b0, K_JAL);
    addVec("lui",   7'h37, 3'd3, 7'h2a, 4'd0, 1'b1, K_LUI);
    addVec("fence", 7'h0f, 3'd0, 7'h00, 4'd0, 1'b0, K_ILL);
    addVec("ecall", 7'h73, 3'd0, 7'h00, 4'd0, 1'b0, K_ILL);
    addVec("zero",  7'h00, 3'd0, 7'h00, 4'd0, 1'b0, K_ILL);

    rst_n = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0;
    alu_zero = 1'b0; alu_lt = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; trap_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.ctrl", {13'b0, got}, 32'd0);
    checkOutput("reset.retired", retired, 32'd0);
    releaseReset("boot");

    // Every table entry with zero wait states
    foreach (vecs[i])
      runInstr({"tbl.", vecs[i].name}, vecs[i], 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Multi-cycle corner cases
    runInstr("lw_wait3",    vecs[findVec("lw")],  0, 3, 1'b0, 1'b0);
    runInstr("bne_z1",      vecs[findVec("bne")], 0, 0, 1'b1, 1'b0);
    runInstr("bne_z0",      vecs[findVec("bne")], 0, 0, 1'b0, 1'b0);
    runInstr("sw_dtimeout", vecs[findVec("sw")],  0, 1000, 1'b0, 1'b0);
    runInstr("add_itimeout", vecs[findVec("add")], TO + 1, 0, 1'b0, 1'b0);
    runInstr("add_iedge",   vecs[findVec("add")], TO, 0, 1'b0, 1'b0);
    runInstr("lw_dedge",    vecs[findVec("lw")],  2, TO, 1'b0, 1'b0);
    runInstr("sw_dtimeout_edge", vecs[findVec("sw")], 0, TO + 1, 1'b0, 1'b0);

    // Reset asserted mid-MEM of a stalled store
    v = vecs[findVec("sw")];
    opcode = v.op; funct3 = v.f3; funct7 = v.f7;
    @(negedge clk); imem_ready = 1'b1;
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    e = '0; e.dmem_req = 1'b1; e.mem_write = 1'b1;
    checkOutput("rstmem.pre", {13'b0, got}, {13'b0, e});
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmem.ctrl", {13'b0, got}, 32'd0);
    checkOutput("rstmem.retired", retired, 32'd0);
    modelRetired = 0;
    releaseReset("rstmem");

    // Randomized instruction stream
    for (int n = 0; n < 100; n++) begin
      v = vecs[$urandom_range(0, vecs.size() - 1)];
      r = $urandom_range(0, 19);
      iw = (r < 16) ? $urandom_range(0, 3) : (r == 16) ? TO : (r == 17) ? TO + 1 : $urandom_range(4, TO - 1);
      r = $urandom_range(0, 19);
      dw = (r < 16) ? $urandom_range(0, 3) : (r == 16) ? TO : (r == 17) ? TO + 1 : $urandom_range(4, TO - 1);
      runInstr($sformatf("rnd%0d.%s", n, v.name), v, iw, dw,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
